// File: rtl/memory_load_store_unit.sv
// memory_load_store_unit
// Bridges the RV32 core's load/store path onto four byte-wide block memories
// used as byte lanes 0..3 of an 8 KiB data memory (port A of each memory).
// One request is handled at a time: IDLE -> (ACCESS -> (CAPTURE) ->) RESPOND.
// Stores write in ACCESS; loads read in ACCESS, the memories' registered
// output is extracted and extended in CAPTURE, and RESPOND holds the result
// until the consumer takes it.

module memory_load_store_unit #(
  parameter logic [31:0] base_address = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [31:0] request_address,
  input  logic        request_is_store,
  input  logic [2:0]  request_funct3,
  input  logic [31:0] request_store_data,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_load_data,
  output logic        response_error,
  output logic [10:0] bank_address,
  output logic [3:0]  bank_write_enable,
  output logic [31:0] bank_write_data,
  input  logic [31:0] bank_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [10:0] bank_address_q, bank_address_d;
  logic [3:0]  lane_enable_q, lane_enable_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] load_data_q, load_data_d;
  logic        error_q, error_d;

  // Request decode results (combinational, from the live request inputs)
  logic        funct3_illegal_s;
  logic        misaligned_s;
  logic        out_of_range_s;
  logic        request_error_s;
  logic [3:0]  request_lanes_s;
  logic [31:0] request_wdata_s;

  // Load extraction results (from the registered request and bank_read_data)
  logic [31:0] shifted_read_s;
  logic [31:0] extended_read_s;

  // Classify the incoming request: illegal funct3, misalignment, range
  always_comb begin
    funct3_illegal_s = 1'b0;
    misaligned_s     = 1'b0;
    case (request_funct3)
      F3_B: begin
        funct3_illegal_s = 1'b0;
        misaligned_s     = 1'b0;
      end
      F3_H: begin
        funct3_illegal_s = 1'b0;
        misaligned_s     = request_address[0];
      end
      F3_W: begin
        funct3_illegal_s = 1'b0;
        misaligned_s     = (request_address[1:0] != 2'b00);
      end
      F3_BU: begin
        // Unsigned byte exists only as a load
        funct3_illegal_s = request_is_store;
        misaligned_s     = 1'b0;
      end
      F3_HU: begin
        funct3_illegal_s = request_is_store;
        misaligned_s     = request_address[0];
      end
      default: begin
        funct3_illegal_s = 1'b1;
        misaligned_s     = 1'b0;
      end
    endcase
    out_of_range_s  = (request_address[31:13] != base_address[31:13]);
    request_error_s = funct3_illegal_s | misaligned_s | out_of_range_s;
  end

  // Store lane enables and lane-replicated store data for the incoming request
  always_comb begin
    request_lanes_s = 4'b0000;
    request_wdata_s = request_store_data;
    case (request_funct3[1:0])
      2'b00: begin
        request_lanes_s = 4'b0001 << request_address[1:0];
        request_wdata_s = {4{request_store_data[7:0]}};
      end
      2'b01: begin
        request_lanes_s = request_address[1] ? 4'b1100 : 4'b0011;
        request_wdata_s = {2{request_store_data[15:0]}};
      end
      2'b10: begin
        request_lanes_s = 4'b1111;
        request_wdata_s = request_store_data;
      end
      default: begin
        request_lanes_s = 4'b0000;
        request_wdata_s = request_store_data;
      end
    endcase
  end

  // Align the read word to the addressed byte and sign/zero-extend
  always_comb begin
    shifted_read_s  = bank_read_data >> {offset_q, 3'b000};
    extended_read_s = shifted_read_s;
    case (funct3_q)
      F3_B:    extended_read_s = {{24{shifted_read_s[7]}}, shifted_read_s[7:0]};
      F3_BU:   extended_read_s = {24'h00_0000, shifted_read_s[7:0]};
      F3_H:    extended_read_s = {{16{shifted_read_s[15]}}, shifted_read_s[15:0]};
      F3_HU:   extended_read_s = {16'h0000, shifted_read_s[15:0]};
      default: extended_read_s = shifted_read_s;
    endcase
  end

  // Next-state and datapath register updates for the request FSM
  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    funct3_d       = funct3_q;
    is_store_d     = is_store_q;
    bank_address_d = bank_address_q;
    lane_enable_d  = lane_enable_q;
    write_data_d   = write_data_q;
    load_data_d    = load_data_q;
    error_d        = error_q;
    case (state_q)
      ST_IDLE: begin
        if (request_valid) begin
          offset_d    = request_address[1:0];
          funct3_d    = request_funct3;
          is_store_d  = request_is_store;
          error_d     = request_error_s;
          load_data_d = 32'h0000_0000;
          if (request_error_s) begin
            // bank_address keeps its previous value; nothing is written
            lane_enable_d = 4'b0000;
            state_d       = ST_RESPOND;
          end else begin
            bank_address_d = request_address[12:2];
            lane_enable_d  = request_is_store ? request_lanes_s : 4'b0000;
            write_data_d   = request_wdata_s;
            state_d        = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        lane_enable_d = 4'b0000;
        if (is_store_q) begin
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // The memories' registered output holds the word read during ACCESS
        load_data_d = extended_read_s;
        state_d     = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (response_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESPOND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      offset_q       <= 2'b00;
      funct3_q       <= 3'b000;
      is_store_q     <= 1'b0;
      bank_address_q <= 11'h000;
      lane_enable_q  <= 4'b0000;
      write_data_q   <= 32'h0000_0000;
      load_data_q    <= 32'h0000_0000;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      offset_q       <= offset_d;
      funct3_q       <= funct3_d;
      is_store_q     <= is_store_d;
      bank_address_q <= bank_address_d;
      lane_enable_q  <= lane_enable_d;
      write_data_q   <= write_data_d;
      load_data_q    <= load_data_d;
      error_q        <= error_d;
    end
  end

  assign request_ready      = (state_q == ST_IDLE);
  assign response_valid     = (state_q == ST_RESPOND);
  assign response_load_data = load_data_q;
  assign response_error     = error_q;
  assign bank_address       = bank_address_q;
  assign bank_write_data    = write_data_q;
  // Reset gates the enables directly so a store caught by reset never writes
  assign bank_write_enable  = ((state_q == ST_ACCESS) && !reset) ? lane_enable_q : 4'b0000;

endmodule

// File: tb/tb_memory_load_store_unit.sv
// tb_memory_load_store_unit
// Directed bench with a byte-lane memory model and a response scoreboard.

module tb_memory_load_store_unit;

  logic        clk;
  logic        reset;
  logic        request_valid;
  logic        request_ready;
  logic [31:0] request_address;
  logic        request_is_store;
  logic [2:0]  request_funct3;
  logic [31:0] request_store_data;
  logic        response_valid;
  logic        response_ready;
  logic [31:0] response_load_data;
  logic        response_error;
  logic [10:0] bank_address;
  logic [3:0]  bank_write_enable;
  logic [31:0] bank_write_data;
  logic [31:0] bank_read_data;

  int checks;
  int failures;

  logic [32:0] sb_q[$];

  logic [7:0] mem_lane [4][2048];

  memory_load_store_unit #(.base_address(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .request_valid      (request_valid),
    .request_ready      (request_ready),
    .request_address    (request_address),
    .request_is_store   (request_is_store),
    .request_funct3     (request_funct3),
    .request_store_data (request_store_data),
    .response_valid     (response_valid),
    .response_ready     (response_ready),
    .response_load_data (response_load_data),
    .response_error     (response_error),
    .bank_address       (bank_address),
    .bank_write_enable  (bank_write_enable),
    .bank_write_data    (bank_write_data),
    .bank_read_data     (bank_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four 2Kx8 port-A memories, read-first with registered read output
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bank_write_enable[l]) mem_lane[l][bank_address] <= bank_write_data[8*l +: 8];
      bank_read_data[8*l +: 8] <= mem_lane[l][bank_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, check the ACCESS-cycle bank outputs, latency and the
  // scoreboarded response, optionally holding response_ready low for a while.
  task automatic issue(input string tag, input logic [31:0] addr, input logic st,
                       input logic [2:0] f3, input logic [31:0] sd,
                       input logic exp_err, input logic [31:0] exp_data, input int exp_lat,
                       input logic [3:0] exp_we, input logic [31:0] exp_wd, input int hold);
    logic [32:0] exp;
    logic [3:0]  we_seen;
    logic [31:0] held_data;
    logic        held_err;
    int          cyc;
    sb_q.push_back({exp_err, exp_data});
    cyc = 0;
    while (!request_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_req_ready"}, {31'd0, request_ready}, 32'd1);
    request_valid      = 1'b1;
    request_address    = addr;
    request_is_store   = st;
    request_funct3     = f3;
    request_store_data = sd;
    @(posedge clk); #1;
    request_valid      = 1'b0;
    request_address    = $urandom;
    request_store_data = $urandom;
    cyc     = 1;
    we_seen = bank_write_enable;
    if (!exp_err) check({tag, "_bank_addr"}, {21'd0, bank_address}, {21'd0, addr[12:2]});
    if (exp_we != 4'b0000) check({tag, "_wdata"}, bank_write_data, exp_wd);
    while (!response_valid && cyc < 10) begin
      @(posedge clk); #1; cyc++;
      we_seen = we_seen | bank_write_enable;
    end
    check({tag, "_resp_valid"}, {31'd0, response_valid}, 32'd1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_we"}, {28'd0, we_seen}, {28'd0, exp_we});
    exp = sb_q.pop_front();
    check({tag, "_data"}, response_load_data, exp[31:0]);
    check({tag, "_err"}, {31'd0, response_error}, {31'd0, exp[32]});
    held_data = response_load_data;
    held_err  = response_error;
    for (int k = 0; k < hold; k++) begin
      // A competing request must be ignored while the response is pending
      request_valid    = 1'b1;
      request_address  = 32'h0000_0100;
      request_is_store = 1'b0;
      request_funct3   = 3'b010;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, response_valid}, 32'd1);
      check({tag, "_hold_data"}, response_load_data, held_data);
      check({tag, "_hold_err"}, {31'd0, response_error}, {31'd0, held_err});
      check({tag, "_hold_rdy"}, {31'd0, request_ready}, 32'd0);
    end
    request_valid  = 1'b0;
    response_ready = 1'b1;
    @(posedge clk); #1;
    response_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, response_valid}, 32'd0);
    check({tag, "_idle_rdy"}, {31'd0, request_ready}, 32'd1);
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    reset              = 1'b1;
    request_valid      = 1'b0;
    request_address    = 32'h0;
    request_is_store   = 1'b0;
    request_funct3     = 3'b000;
    request_store_data = 32'h0;
    response_ready     = 1'b0;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 2048; a++) mem_lane[l][a] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, response_valid}, 32'd0);
    check("rst_data", response_load_data, 32'd0);
    check("rst_err", {31'd0, response_error}, 32'd0);
    check("rst_bank_addr", {21'd0, bank_address}, 32'd0);
    check("rst_we", {28'd0, bank_write_enable}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", {31'd0, request_ready}, 32'd1);

    // Word store/load round trip
    issue("sw100", 32'h100, 1'b1, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 2, 4'b1111, 32'hDEADBEEF, 0);
    issue("lw100", 32'h100, 1'b0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 3, 4'b0000, 32'h0, 0);

    // Sub-word loads with sign and zero extension
    issue("lb103",  32'h103, 1'b0, 3'b000, 32'h0, 1'b0, 32'hFFFFFFDE, 3, 4'b0000, 32'h0, 0);
    issue("lbu103", 32'h103, 1'b0, 3'b100, 32'h0, 1'b0, 32'h000000DE, 3, 4'b0000, 32'h0, 0);
    issue("lh102",  32'h102, 1'b0, 3'b001, 32'h0, 1'b0, 32'hFFFFDEAD, 3, 4'b0000, 32'h0, 0);
    issue("lhu100", 32'h100, 1'b0, 3'b101, 32'h0, 1'b0, 32'h0000BEEF, 3, 4'b0000, 32'h0, 0);

    // Top word, lane 3
    issue("sb1fff",  32'h1FFF, 1'b1, 3'b000, 32'h1234565A, 1'b0, 32'h0, 2, 4'b1000, 32'h5A5A5A5A, 0);
    issue("lbu1fff", 32'h1FFF, 1'b0, 3'b100, 32'h0, 1'b0, 32'h0000005A, 3, 4'b0000, 32'h0, 0);

    // Halfword store to the upper half, then read back the merged word
    issue("sh202", 32'h202, 1'b1, 3'b001, 32'hAAAA8001, 1'b0, 32'h0, 2, 4'b1100, 32'h80018001, 0);
    issue("lh202", 32'h202, 1'b0, 3'b001, 32'h0, 1'b0, 32'hFFFF8001, 3, 4'b0000, 32'h0, 0);

    // Error cases: single-cycle response, no writes
    issue("e_lw102",  32'h102,  1'b0, 3'b010, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0, 0);
    issue("e_sh001",  32'h001,  1'b1, 3'b001, 32'hFFFF, 1'b1, 32'h0, 1, 4'b0000, 32'h0, 0);
    issue("e_lw2000", 32'h2000, 1'b0, 3'b010, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0, 0);
    issue("e_f3_011", 32'h0,    1'b0, 3'b011, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0, 0);
    issue("e_sbu",    32'h100,  1'b1, 3'b100, 32'h77, 1'b1, 32'h0, 1, 4'b0000, 32'h0, 0);
    issue("e_f3_110", 32'h100,  1'b0, 3'b110, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0, 0);
    // The rejected stores above must have left memory untouched
    issue("lw100b", 32'h100, 1'b0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 3, 4'b0000, 32'h0, 0);

    // Backpressure on the response
    issue("hold_lw", 32'h100, 1'b0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 3, 4'b0000, 32'h0, 5);

    // Reset landing on the ACCESS cycle of a store
    issue("sw0", 32'h0, 1'b1, 3'b010, 32'hCAFEF00D, 1'b0, 32'h0, 2, 4'b1111, 32'hCAFEF00D, 0);
    request_valid      = 1'b1;
    request_address    = 32'h0;
    request_is_store   = 1'b1;
    request_funct3     = 3'b010;
    request_store_data = 32'h11223344;
    @(posedge clk); #1;
    request_valid = 1'b0;
    reset         = 1'b1;
    #1;
    check("rstacc_we", {28'd0, bank_write_enable}, 32'd0);
    @(posedge clk); #1;
    check("rstacc_resp_valid", {31'd0, response_valid}, 32'd0);
    check("rstacc_data", response_load_data, 32'd0);
    check("rstacc_err", {31'd0, response_error}, 32'd0);
    check("rstacc_bank_addr", {21'd0, bank_address}, 32'd0);
    check("rstacc_we2", {28'd0, bank_write_enable}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstacc_no_resp", {31'd0, response_valid}, 32'd0);
    issue("lw0", 32'h0, 1'b0, 3'b010, 32'h0, 1'b0, 32'hCAFEF00D, 3, 4'b0000, 32'h0, 0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
